// File: rtl/spi_flash_reader.sv
// Sequencer for the SPI byte engine: optional wake (0xAB), then READ + 24-bit address, then
// len dummy bytes whose received values are streamed out on a valid/ready interface.
module spi_flash_reader #(
    parameter int unsigned LEN_W       = 16,
    parameter logic [7:0]  CMD_READ    = 8'h03,
    parameter bit          WAKE_EN     = 1'b1,
    parameter int unsigned WAKE_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             spi_load,
    output logic [15:0]      spi_in,
    input  logic [15:0]      spi_out
);

    localparam logic [15:0] SpiDesel = 16'h0100;
    localparam logic [7:0]  CmdWake  = 8'hAB;
    localparam int unsigned CntW     = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [3:0] {
        StInit, StIdle, StWake, StWdesel, StWwait, StCmd,
        StA2, StA1, StA0, StData, StDesel, StDone
    } state_e;

    // Sub-phase of every byte send: load pulse, ignored cycle, wait for SPI idle, hold for consumer
    typedef enum logic [1:0] {PhLoad, PhSkip, PhWait, PhHold} phase_e;

    state_e           state;
    phase_e           phase;
    logic [23:0]      addr_q;
    logic [LEN_W-1:0] remaining;
    logic [CntW-1:0]  wait_cnt;
    logic             spi_busy;
    logic             unused_spi_out;

    assign spi_busy       = spi_out[15];
    assign unused_spi_out = ^spi_out[14:8];

    function automatic state_e hdr_next(input state_e s);
        case (s)
            StCmd:   return StA2;
            StA2:    return StA1;
            StA1:    return StA0;
            default: return StData;
        endcase
    endfunction

    function automatic logic [7:0] hdr_byte(input state_e s, input logic [23:0] a);
        case (s)
            StA2:    return a[23:16];
            StA1:    return a[15:8];
            StA0:    return a[7:0];
            default: return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StInit;
            phase      <= PhLoad;
            busy       <= 1'b1;
            done       <= 1'b0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            spi_load   <= 1'b0;
            spi_in     <= 16'h0000;
            addr_q     <= 24'h000000;
            remaining  <= '0;
            wait_cnt   <= '0;
        end else begin
            spi_load <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                // Force CSX high in case reset landed mid-transfer
                StInit: begin
                    spi_load <= 1'b1;
                    spi_in   <= SpiDesel;
                    busy     <= 1'b0;
                    state    <= StIdle;
                end
                StIdle: begin
                    if (start) begin
                        addr_q    <= addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        phase     <= PhLoad;
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end else if (WAKE_EN) begin
                            state    <= StWake;
                            spi_load <= 1'b1;
                            spi_in   <= {8'h00, CmdWake};
                        end else begin
                            state    <= StCmd;
                            spi_load <= 1'b1;
                            spi_in   <= {8'h00, CMD_READ};
                        end
                    end
                end
                StWake, StCmd, StA2, StA1, StA0, StData: begin
                    unique case (phase)
                        PhLoad: phase <= PhSkip;
                        // SPI busy is registered a cycle late, so this cycle's flag is stale
                        PhSkip: phase <= PhWait;
                        PhWait: begin
                            if (!spi_busy) begin
                                if (state == StData) begin
                                    data       <= spi_out[7:0];
                                    data_valid <= 1'b1;
                                    remaining  <= remaining - LEN_W'(1);
                                    phase      <= PhHold;
                                end else if (state == StWake) begin
                                    state    <= StWdesel;
                                    spi_load <= 1'b1;
                                    spi_in   <= SpiDesel;
                                end else begin
                                    state    <= hdr_next(state);
                                    phase    <= PhLoad;
                                    spi_load <= 1'b1;
                                    spi_in   <= {8'h00, hdr_byte(hdr_next(state), addr_q)};
                                end
                            end
                        end
                        PhHold: begin
                            // CSX stays low while stalled; the flash keeps its read pointer
                            if (data_ready) begin
                                data_valid <= 1'b0;
                                spi_load   <= 1'b1;
                                if (remaining == '0) begin
                                    state  <= StDesel;
                                    spi_in <= SpiDesel;
                                end else begin
                                    phase  <= PhLoad;
                                    spi_in <= 16'h0000;
                                end
                            end
                        end
                    endcase
                end
                StWdesel: begin
                    wait_cnt <= CntW'(WAKE_CYCLES - 1);
                    state    <= StWwait;
                end
                StWwait: begin
                    if (wait_cnt == '0) begin
                        state    <= StCmd;
                        phase    <= PhLoad;
                        spi_load <= 1'b1;
                        spi_in   <= {8'h00, CMD_READ};
                    end else begin
                        wait_cnt <= wait_cnt - CntW'(1);
                    end
                end
                StDesel: begin
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule
